// File: rtl/soc_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : soc_run_ctrl
// Brief   : Command-driven reset/clock-enable sequencer for the MIPS core with
//           a circular PC/write-back trace buffer.
// Revision: 1.0 - initial release
// ============================================================================
module soc_run_ctrl #(
  parameter int CNT_W       = 8,
  parameter int RST_CYCLES  = 2,
  parameter int TRACE_DEPTH = 16,
  parameter int AW          = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             stop,
  input  logic [5:0]       pc_in,
  input  logic [7:0]       wb_in,
  input  logic [2:0]       exc_in,
  output logic             core_rst,
  output logic             core_ce,
  output logic             busy,
  output logic [CNT_W-1:0] cycles_done,
  output logic             halted_on_exc,
  output logic [2:0]       exc_code,
  input  logic [AW-1:0]    trc_rd_addr,
  output logic [13:0]      trc_rd_data,
  output logic [AW:0]      trc_count
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RSTSEQ = 2'd1,
    S_RUN    = 2'd2,
    S_FREE   = 2'd3
  } state_t;

  localparam logic [1:0]       c_OP_RST  = 2'd0;
  localparam logic [1:0]       c_OP_STEP = 2'd1;
  localparam logic [1:0]       c_OP_RUN  = 2'd2;
  localparam int               c_RW      = (RST_CYCLES > 1) ? $clog2(RST_CYCLES + 1) : 1;
  localparam logic [c_RW-1:0]  c_RST_LD  = c_RW'(RST_CYCLES - 1);
  localparam logic [c_RW-1:0]  c_RST_ONE = c_RW'(1);
  localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);
  localparam logic [AW:0]      c_DEPTH   = (AW + 1)'(TRACE_DEPTH);
  localparam logic [AW:0]      c_TRC_ONE = (AW + 1)'(1);
  localparam logic [AW-1:0]    c_PTR_ONE = AW'(1);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_remain;
  logic [c_RW-1:0]  r_rst_cnt;
  logic [CNT_W-1:0] r_cycles;
  logic [AW-1:0]    r_wrptr;
  logic [AW:0]      r_trc_cnt;
  logic             r_core_rst;
  logic             r_core_ce;
  logic             r_halt_exc;
  logic [2:0]       r_exc_code;
  logic [13:0]      r_mem [TRACE_DEPTH];

  logic             w_accept;
  logic             w_rst_acc;
  logic             w_run_acc;
  logic             w_exc;
  logic [AW-1:0]    w_rd_phys;
  logic             w_rd_valid;

  assign w_accept  = cmd_valid && (r_state == S_IDLE);
  assign w_rst_acc = w_accept && (cmd_op == c_OP_RST);
  assign w_run_acc = w_accept && ((cmd_op == c_OP_STEP) || (cmd_op == c_OP_RUN));

  always_comb begin
    w_next = r_state;
    w_exc  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            c_OP_RST:  w_next = S_RSTSEQ;
            c_OP_STEP: w_next = S_RUN;
            // A zero-length run is accepted but never leaves IDLE.
            c_OP_RUN:  w_next = (cmd_count != '0) ? S_RUN : S_IDLE;
            default:   w_next = S_FREE;
          endcase
        end
      end
      S_RSTSEQ: begin
        if (r_rst_cnt == '0) w_next = S_IDLE;
      end
      S_RUN, S_FREE: begin
        w_exc = (exc_in != 3'd0);
        if (w_exc || stop || ((r_state == S_RUN) && (r_remain == c_CNT_ONE)))
          w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_core_rst <= 1'b1;
      r_core_ce  <= 1'b0;
      r_remain   <= '0;
      r_rst_cnt  <= '0;
      r_cycles   <= '0;
      r_wrptr    <= '0;
      r_trc_cnt  <= '0;
      r_halt_exc <= 1'b0;
      r_exc_code <= '0;
    end else begin
      r_state    <= w_next;
      r_core_rst <= (w_next == S_RSTSEQ);
      r_core_ce  <= (w_next == S_RUN) || (w_next == S_FREE);

      if (w_rst_acc) begin
        r_rst_cnt <= c_RST_LD;
      end else if ((r_state == S_RSTSEQ) && (r_rst_cnt != '0)) begin
        r_rst_cnt <= r_rst_cnt - c_RST_ONE;
      end

      if (w_run_acc) begin
        r_remain <= (cmd_op == c_OP_STEP) ? c_CNT_ONE : cmd_count;
      end else if (r_state == S_RUN) begin
        r_remain <= r_remain - c_CNT_ONE;
      end

      if (w_rst_acc) begin
        r_cycles   <= '0;
        r_wrptr    <= '0;
        r_trc_cnt  <= '0;
        r_halt_exc <= 1'b0;
        r_exc_code <= '0;
      end else if (r_core_ce) begin
        r_wrptr <= r_wrptr + c_PTR_ONE;
        if (r_trc_cnt != c_DEPTH) r_trc_cnt <= r_trc_cnt + c_TRC_ONE;
        if (r_cycles != '1)       r_cycles  <= r_cycles + c_CNT_ONE;
        if (w_exc) begin
          r_halt_exc <= 1'b1;
          r_exc_code <= exc_in;
        end
      end
    end
  end

  // Trace storage carries no reset; validity is tracked by r_trc_cnt.
  always_ff @(posedge clk) begin
    if (r_core_ce) r_mem[r_wrptr] <= {pc_in, wb_in};
  end

  assign w_rd_phys   = r_wrptr - r_trc_cnt[AW-1:0] + trc_rd_addr;
  assign w_rd_valid  = ({1'b0, trc_rd_addr} < r_trc_cnt);
  assign trc_rd_data = w_rd_valid ? r_mem[w_rd_phys] : 14'd0;

  assign cmd_ready     = (r_state == S_IDLE);
  assign busy          = (r_state != S_IDLE);
  assign core_rst      = r_core_rst;
  assign core_ce       = r_core_ce;
  assign cycles_done   = r_cycles;
  assign halted_on_exc = r_halt_exc;
  assign exc_code      = r_exc_code;
  assign trc_count     = r_trc_cnt;

endmodule
`default_nettype wire

// File: tb/tb_soc_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_soc_run_ctrl
// Brief   : Directed/random bench for soc_run_ctrl with a queue-based model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_soc_run_ctrl;
  localparam int CNT_W = 8;
  localparam int RST_CYCLES = 2;
  localparam int DEPTH = 16;
  localparam int AW = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_op = 2'd0;
  logic [CNT_W-1:0] cmd_count = '0;
  logic             stop = 1'b0;
  logic [5:0]       pc_in = '0;
  logic [7:0]       wb_in = '0;
  logic [2:0]       exc_in = '0;
  logic             core_rst;
  logic             core_ce;
  logic             busy;
  logic [CNT_W-1:0] cycles_done;
  logic             halted_on_exc;
  logic [2:0]       exc_code;
  logic [AW-1:0]    trc_rd_addr = '0;
  logic [13:0]      trc_rd_data;
  logic [AW:0]      trc_count;

  always #5 clk = ~clk;

  soc_run_ctrl #(
    .CNT_W(CNT_W), .RST_CYCLES(RST_CYCLES), .TRACE_DEPTH(DEPTH), .AW(AW)
  ) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_count(cmd_count), .stop(stop), .pc_in(pc_in),
    .wb_in(wb_in), .exc_in(exc_in), .core_rst(core_rst), .core_ce(core_ce),
    .busy(busy), .cycles_done(cycles_done), .halted_on_exc(halted_on_exc),
    .exc_code(exc_code), .trc_rd_addr(trc_rd_addr), .trc_rd_data(trc_rd_data),
    .trc_count(trc_count)
  );

  int n_tests = 0;
  int n_fail = 0;

  // Reference model: executed-cycle history as a bounded queue.
  logic [13:0] m_trace[$];
  int          m_cycles;
  logic        m_halt_exc;
  logic [2:0]  m_exc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_trace.delete();
    m_cycles   = 0;
    m_halt_exc = 1'b0;
    m_exc      = 3'd0;
  endtask

  task automatic model_exec(input logic [13:0] entry);
    m_trace.push_back(entry);
    if (m_trace.size() > DEPTH) void'(m_trace.pop_front());
    if (m_cycles < (1 << CNT_W) - 1) m_cycles++;
  endtask

  task automatic check_state(input string tag);
    logic [13:0] exp;
    chk({tag, "_cycles"}, cycles_done, m_cycles);
    chk({tag, "_trc_count"}, trc_count, m_trace.size());
    chk({tag, "_halted_exc"}, halted_on_exc, m_halt_exc);
    chk({tag, "_exc_code"}, exc_code, m_exc);
    for (int a = 0; a < DEPTH; a++) begin
      trc_rd_addr = AW'(a);
      #1;
      exp = (a < m_trace.size()) ? m_trace[a] : 14'd0;
      chk({tag, "_trace"}, trc_rd_data, exp);
    end
    @(negedge clk);
  endtask

  task automatic do_reset_cmd(input string tag);
    int rst_seen;
    int ce_seen;
    chk({tag, "_ready"}, cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_op    = 2'd0;
    cmd_count = CNT_W'($urandom);
    @(negedge clk);
    cmd_valid = 1'b0;
    rst_seen  = 0;
    ce_seen   = 0;
    for (int k = 0; k < 6; k++) begin
      if (core_rst === 1'b1) rst_seen++;
      if (core_ce !== 1'b0) ce_seen++;
      @(negedge clk);
    end
    chk({tag, "_rst_cycles"}, rst_seen, RST_CYCLES);
    chk({tag, "_ce_during_rst"}, ce_seen, 0);
    model_clear();
    check_state(tag);
  endtask

  // pcbase < 0 selects random PCs; exc_at/stop_at < 0 disable those events.
  task automatic do_cmd(input string tag, input logic [1:0] op, input logic [7:0] cnt,
                        input int nexp, input int exc_at, input int stop_at,
                        input logic [2:0] excv, input int pcbase);
    int         seen;
    logic [5:0] pc;
    logic [7:0] wb;
    chk({tag, "_ready"}, cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_count = cnt;
    @(negedge clk);
    cmd_valid = 1'b0;
    seen      = 0;
    for (int k = 0; k < nexp; k++) begin
      pc     = (pcbase >= 0) ? 6'(pcbase + k) : 6'($urandom);
      wb     = 8'($urandom);
      pc_in  = pc;
      wb_in  = wb;
      exc_in = (k == exc_at) ? excv : 3'd0;
      stop   = (k == stop_at);
      if (core_ce === 1'b1) seen++;
      model_exec({pc, wb});
      if (k == exc_at && excv != 3'd0) begin
        m_halt_exc = 1'b1;
        m_exc      = excv;
      end
      @(negedge clk);
    end
    exc_in = 3'd0;
    stop   = 1'b0;
    chk({tag, "_ready_after"}, cmd_ready, 1);
    for (int k = 0; k < 4; k++) begin
      if (core_ce === 1'b1) seen++;
      @(negedge clk);
    end
    chk({tag, "_ce_cycles"}, seen, nexp);
    check_state(tag);
  endtask

  initial begin
    int n;
    model_clear();

    repeat (2) @(negedge clk);
    chk("rst_core_rst", core_rst, 1);
    chk("rst_core_ce", core_ce, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cycles", cycles_done, 0);
    chk("rst_trc_count", trc_count, 0);
    chk("rst_halted", halted_on_exc, 0);
    chk("rst_exc_code", exc_code, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("rel_core_rst", core_rst, 0);
    chk("rel_ready", cmd_ready, 1);

    do_reset_cmd("rstcmd");

    for (int i = 0; i < 3; i++) do_cmd("step", 2'd1, 8'd77, 1, -1, -1, 3'd0, i);

    do_cmd("run5", 2'd2, 8'd5, 5, -1, -1, 3'd0, -1);
    do_cmd("run0", 2'd2, 8'd0, 0, -1, -1, 3'd0, -1);
    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(1, 12);
      do_cmd("rand_run", 2'd2, 8'(n), n, -1, -1, 3'd0, -1);
    end
    do_cmd("early_stop", 2'd2, 8'd10, 4, -1, 3, 3'd0, -1);

    do_reset_cmd("rst_exc");
    do_cmd("free_exc", 2'd3, 8'd0, 7, 6, -1, 3'b010, -1);
    do_reset_cmd("rst_exc2");
    do_cmd("free_exc_stop", 2'd3, 8'd0, 7, 6, 6, 3'b010, -1);

    do_reset_cmd("rst_wrap");
    do_cmd("wrap", 2'd2, 8'd20, 20, -1, -1, 3'd0, 0);
    trc_rd_addr = 4'd0;
    #1 chk("wrap_addr0_pc", trc_rd_data[13:8], 4);
    trc_rd_addr = 4'd15;
    #1 chk("wrap_addr15_pc", trc_rd_data[13:8], 19);
    @(negedge clk);

    // Asynchronous reset partway through a run-N.
    cmd_valid = 1'b1;
    cmd_op    = 2'd2;
    cmd_count = 8'd10;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("abort_core_ce", core_ce, 0);
    chk("abort_core_rst", core_rst, 1);
    chk("abort_trc_count", trc_count, 0);
    chk("abort_busy", busy, 0);
    chk("abort_cycles", cycles_done, 0);
    @(negedge clk);
    rst = 1'b1;
    model_clear();
    @(negedge clk);
    chk("abort_rel_core_rst", core_rst, 0);

    do_reset_cmd("rst_sat");
    do_cmd("sat", 2'd3, 8'd0, 300, -1, 299, 3'd0, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/soc_run_ctrl.md
# soc_run_ctrl

On-chip run controller for the single-cycle MIPS SoC (`Soc_Mips`). It replaces hand-toggled bench clocks with a command-driven sequencer that issues the core reset pulse and gates the core clock enable: single step, run-N or free-run. It halts on stop or on any exception cause. A circular trace buffer records PC and write-back values for each executed cycle. It sits between the board/debug command source and the core's `rst` and clock-enable inputs.

## Interface
- `CNT_W`, 8: width of the run count and of the executed-cycle counter.
- `RST_CYCLES`, 2: number of cycles `core_rst` is held high per reset command (≥1).
- `TRACE_DEPTH`, 16: trace entries; power of two, ≥2.
- `AW`, 4: trace address width, log2(`TRACE_DEPTH`).
- `clk` in 1: single clock for the controller and core.
- `rst` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: controller can accept a command.
- `cmd_op` in 2: 0 = reset core, 1 = step, 2 = run-N, 3 = free-run.
- `cmd_count` in `CNT_W`: N for run-N; ignored otherwise.
- `stop` in 1: halt request, level-sampled.
- `pc_in` in 6: core PCout.
- `wb_in` in 8: core WriteBack.
- `exc_in` in 3: core ExceptionCause; nonzero means exception.
- `core_rst` out 1: active-high reset to the core.
- `core_ce` out 1: core clock enable.
- `busy` out 1: high whenever the state is not IDLE.
- `cycles_done` out `CNT_W`: enabled cycles since the last core reset; saturating.
- `halted_on_exc` out 1: the last run ended on an exception.
- `exc_code` out 3: `exc_in` value captured at the halt.
- `trc_rd_addr` in `AW`: read index; 0 = oldest valid entry.
- `trc_rd_data` out 14: {pc, wb}; combinational read.
- `trc_count` out `AW`+1: valid entries; saturates at `TRACE_DEPTH`.

## Operation
- States: IDLE, RSTSEQ, RUN, FREE.
- A command is accepted when `cmd_valid & cmd_ready`. `cmd_ready` = (state == IDLE).
- **Reset command (op 0):**
  - IDLE→RSTSEQ.
  - `core_rst`=1 and `core_ce`=0 for exactly `RST_CYCLES` cycles, then IDLE.
  - On accept, clear `cycles_done`, `trc_count`, the trace write pointer, `halted_on_exc` and `exc_code`.
- **Step (op 1):** behaves as run-N with N=1.
- **Run-N (op 2):**
  - Load the remaining counter with N, then IDLE→RUN.
  - `core_ce`=1 each RUN cycle; the counter decrements on each.
  - Leave RUN after the cycle in which the counter reaches 1.
  - N=0: no-op. Return to IDLE next cycle with `core_ce` never asserted.
- **Free-run (op 3):** IDLE→FREE. `core_ce`=1 every cycle until halt.
- **Halt in RUN/FREE:**
  - If `stop`=1, or `exc_in`≠0 in a cycle with `core_ce`=1, that cycle still executes (`core_ce` stays high). The state is IDLE next cycle.
  - Exception halt sets `halted_on_exc`=1 and `exc_code`=`exc_in`.
  - `stop` and exception in the same cycle are reported as an exception halt.
  - `stop` is ignored in IDLE and RSTSEQ.
- **Trace:** every cycle with `core_ce`=1 writes {`pc_in`,`wb_in`} (pre-edge values) at the write pointer.
  - The pointer wraps modulo `TRACE_DEPTH`.
  - `trc_count` increments to saturation.
  - Read address is relative to the oldest entry: physical = (wrptr − `trc_count` + `trc_rd_addr`) mod depth.
  - Reads at `trc_rd_addr` ≥ `trc_count` return 0.
- `cycles_done` increments on each `core_ce`=1 cycle and saturates at all-ones.

## Timing
- **Reset values (`rst`=0):**
  - state IDLE, `core_rst`=1 (core held in reset while the controller is in reset), `core_ce`=0.
  - `cmd_ready`=1 after `rst` deasserts.
  - `busy`=0, `cycles_done`=0, `halted_on_exc`=0, `exc_code`=0, `trc_count`=0.
- After `rst` releases, `core_rst` drops to 0 at the first clock edge. Software then issues op 0 before running.
- Command latency: `core_rst` / `core_ce` assert in the cycle after the accept edge.
- Run-N occupies exactly N cycles of `core_ce`. `cmd_ready` returns one cycle after the last enabled cycle.
- All outputs are registered except `cmd_ready`, `busy` (state decodes) and `trc_rd_data`.
- `rst` asserted mid-run aborts immediately (asynchronous). Trace contents are not guaranteed; `trc_count`=0.

## Test plan
- **Reset sequence:** `rst` low 2 cycles then high; op 0 → `core_rst` high exactly 2 cycles, `cycles_done`=0, `trc_count`=0.
- **Step ×3:** with pc stimulus 0,1,2 → 3 single `core_ce` pulses, `cycles_done`=3, trace reads 0→{0,wb0}, 2→{2,wb2}.
- **Run-N boundaries:** N=5 → exactly 5 `core_ce` cycles. N=0 → zero `core_ce` cycles and `cmd_ready` back next cycle.
- **Free-run exception:** free-run with `exc_in`=3'b010 on the 7th enabled cycle → 7 enabled cycles, `halted_on_exc`=1, `exc_code`=2. Same cycle with `stop`=1 gives the same result.
- **Trace wrap:** run-N with N=20 and `TRACE_DEPTH`=16, pc=i → `trc_count`=16, addr0 pc=4, addr15 pc=19.
- **Mid-run reset and saturation:** assert `rst` during run-N with N=10 → `core_ce`=0 and `core_rst`=1 immediately. Free-run 300 cycles (`CNT_W`=8) then `stop` → `cycles_done`=255.
